// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path: op encodings, the
// sequencer FSM state type and the default datapath width.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_regfile.sv
// Register file for the ALU sequencer: NREGS x DATA_W, two asynchronous
// read ports, one synchronous write port. R0 always reads as zero.
module alu_op_regfile #(
    parameter  int DATA_W = 32,
    parameter  int NREGS  = 8,
    localparam int RA_W   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RA_W-1:0]   raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [RA_W-1:0]   raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [RA_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [NREGS];

    // Storage: cleared on reset, written on we; writes to R0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this array is reset on purpose: after reset every
            // register must read 0, so it cannot map to a RAM macro.
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side driver for the external combinational ALU: accepts a
// command, registers operands onto the ALU inputs, writes the result back
// to the register file and returns it over a valid/ready response channel.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter  int DATA_W = alu_pkg::DATA_W,
    parameter  int NREGS  = 8,
    parameter  int IMM_W  = 16,
    localparam int RA_W   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [RA_W-1:0]   cmd_rd,
    input  logic [RA_W-1:0]   cmd_rs1,
    input  logic [RA_W-1:0]   cmd_rs2,
    input  logic              cmd_imm_en,
    input  logic [IMM_W-1:0]  cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic [RA_W-1:0]   rsp_rd
);

    state_t            state;
    logic [RA_W-1:0]   rd_q;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm_sext;
    logic              wb_en;

    assign imm_sext = {{(DATA_W-IMM_W){cmd_imm[IMM_W-1]}}, cmd_imm};

    // Writeback happens on the EXEC edge, so the next command sees it.
    assign wb_en = (state == ST_EXEC);

    alu_op_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (cmd_rs1),
        .rdata1 (rs1_data),
        .raddr2 (cmd_rs2),
        .rdata2 (rs2_data),
        .we     (wb_en),
        .waddr  (rd_q),
        .wdata  (alu_result)
    );

    // Sequencer FSM with registered handshake, ALU-drive and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= OP_ADD;
            rd_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_rd    <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every decision
            // below sees the pre-edge values of the other state registers.
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        alu_a     <= rs1_data;
                        alu_b     <= cmd_imm_en ? imm_sext : rs2_data;
                        alu_op    <= cmd_op;
                        rd_q      <= cmd_rd;
                        cmd_ready <= 1'b0;
                        state     <= ST_EXEC;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    rsp_data  <= alu_result;
                    rsp_zero  <= alu_zero;
                    rsp_rd    <= rd_q;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
